// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction width, NOP encoding and the
// fetch-stage state encoding.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the fetch stage: redirect / sequential / hold,
// plus the misaligned-redirect and out-of-range fetch checks.
module pc_next
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 1 << 20
) (
  input  logic [31:0]  pc,
  input  fetch_state_e state,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         load_allowed,
  output logic [31:0]  pc_next,
  output logic [31:0]  pc_plus4,
  output logic         misaligned,
  output logic         range_fault
);

  // One extra bit so IMEM_WORDS = 2^32 words would still compare correctly.
  localparam logic [32:0] WORD_LIMIT = 33'(IMEM_WORDS);

  assign pc_plus4    = pc + 32'd4;
  assign misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign range_fault = ({1'b0, word_addr(pc)} >= WORD_LIMIT);

  always_comb begin
    pc_next = pc;
    if (state == RUN) begin
      if (redirect_valid) begin
        if (!misaligned) begin
          pc_next = redirect_pc;
        end
      end else if (load_allowed && !range_fault) begin
        pc_next = pc_plus4;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, IF/ID register with valid/ready
// handshake, redirects and sticky fetch fault. FETCH_PERF_EN adds counters.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1 << 20
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4,
  output logic               fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalls
`endif
);

  fetch_state_e       state_reg, state_next;
  logic [31:0]        pc_reg, pc_next_val, pc_plus4;
  logic               misaligned, range_fault;
  logic               load_allowed, in_run;

  logic               if_valid_reg, if_valid_next;
  logic [INSTR_W-1:0] if_instr_reg, if_instr_next;
  logic [31:0]        if_pc_reg, if_pc_next;
  logic [31:0]        if_pc_plus4_reg, if_pc_plus4_next;

  assign load_allowed = !if_valid_reg || id_ready;
  assign in_run       = (state_reg == RUN);

  pc_next #(
    .IMEM_WORDS(IMEM_WORDS)
  ) u_pc_next (
    .pc            (pc_reg),
    .state         (state_reg),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .load_allowed  (load_allowed),
    .pc_next       (pc_next_val),
    .pc_plus4      (pc_plus4),
    .misaligned    (misaligned),
    .range_fault   (range_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // A range fault only matters when a load is actually attempted.
  always_comb begin
    state_next = state_reg;
    if (in_run && (misaligned || (!redirect_valid && load_allowed && range_fault))) begin
      state_next = FAULT;
    end
  end

  always_comb begin
    fetch_fault = (state_reg == FAULT);
  end

  always_comb begin
    if_valid_next    = if_valid_reg;
    if_instr_next    = if_instr_reg;
    if_pc_next       = if_pc_reg;
    if_pc_plus4_next = if_pc_plus4_reg;
    if (!in_run) begin
      if_valid_next = 1'b0;
    end else if (redirect_valid) begin
      if_valid_next = 1'b0;
      if_instr_next = NOP_INSTR;
    end else if (load_allowed) begin
      if (range_fault) begin
        if_valid_next = 1'b0;
      end else begin
        if_valid_next    = 1'b1;
        if_instr_next    = imem_data;
        if_pc_next       = pc_reg;
        if_pc_plus4_next = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      if_valid_reg    <= 1'b0;
      if_instr_reg    <= NOP_INSTR;
      if_pc_reg       <= 32'h0;
      if_pc_plus4_reg <= 32'h0;
    end else begin
      pc_reg          <= pc_next_val;
      if_valid_reg    <= if_valid_next;
      if_instr_reg    <= if_instr_next;
      if_pc_reg       <= if_pc_next;
      if_pc_plus4_reg <= if_pc_plus4_next;
    end
  end

  assign imem_addr   = word_addr(pc_reg);
  assign if_valid    = if_valid_reg;
  assign if_instr    = if_instr_reg;
  assign if_pc       = if_pc_reg;
  assign if_pc_plus4 = if_pc_plus4_reg;

`ifdef FETCH_PERF_EN
  // Index 0 counts handshake transfers, index 1 counts stalled cycles.
  logic [1:0]       perf_inc;
  logic [1:0][31:0] perf_cnt;

  assign perf_inc[0] = if_valid_reg && id_ready;
  assign perf_inc[1] = if_valid_reg && !id_ready;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    logic [31:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= 32'h0;
      end else if (perf_inc[gi]) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
    assign perf_cnt[gi] = cnt_reg;
  end

  assign perf_fetched = perf_cnt[0];
  assign perf_stalls  = perf_cnt[1];
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS core, directly upstream of the instruction memory. It holds the program counter and drives the memory's word address. It captures the returned instruction into an IF/ID output register. It presents that register to decode through a valid/ready handshake, with support for decode back-pressure, control-flow redirects and an out-of-range fetch fault.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; must be word-aligned.
- IMEM_WORDS, 1<<20, number of 32-bit words in instruction memory; word addresses at or above this value are out of range.

Ports:
- clk  input  1  single clock; every register updates on the rising edge.
- rst_n  input  1  reset, asynchronous assertion, active-low.
- imem_addr  output  32  word address to instruction memory, equal to pc >> 2 (zero-extended). Combinational from the PC register.
- imem_data  input  32  instruction word returned combinationally by instruction memory for imem_addr.
- redirect_valid  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  32  byte target address.
- id_ready  input  1  decode accepts the IF/ID register this cycle.
- if_valid  output  1  IF/ID register holds a live instruction.
- if_instr  output  32  fetched instruction.
- if_pc  output  32  byte address of if_instr.
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
- fetch_fault  output  1  sticky out-of-range or misaligned fetch flag.

## Operation
- State machine with states RUN and FAULT; reset enters RUN.
- The handshake transfers when if_valid && id_ready. The IF/ID register may load when it is empty or a transfer occurs.
- RUN, no redirect, load allowed, range check passes:
  - if_instr <= imem_data; if_pc <= pc; if_pc_plus4 <= pc+4; if_valid <= 1.
  - pc <= pc+4.
- RUN, load not allowed (back-pressure): pc, IF/ID register and if_valid all hold unchanged.
- Redirect has priority over back-pressure and over sequential fetch:
  - pc <= redirect_pc.
  - if_valid <= 0 and if_instr <= 32'h0000_0000 (NOP), which squashes the wrong-path instruction.
  - The instruction at redirect_pc is captured the following cycle.
- Range check failure when (pc >> 2) >= IMEM_WORDS during a load attempt:
  - Go to FAULT; fetch_fault <= 1; if_valid <= 0.
  - imem_data is ignored, since it may be X.
- A redirect_pc with bits [1:0] != 0 is a misaligned redirect. It goes to FAULT the next cycle, and pc is not updated.
- FAULT is absorbing until reset:
  - pc frozen, if_valid 0, fetch_fault 1.
  - redirect_valid and id_ready are ignored.
- pc+4 wraps modulo 2^32. With the default IMEM_WORDS, the range check faults long before the wrap.

## Timing
- Reset values:
  - pc = RESET_PC.
  - if_valid 0, if_instr 32'h0, if_pc 32'h0, if_pc_plus4 32'h0.
  - fetch_fault 0; state RUN.
- imem_addr is valid combinationally in the same cycle as pc.
- Latency: one cycle from pc to if_valid/if_instr. First valid instruction appears one cycle after rst_n deasserts.
- Throughput: one instruction per cycle while id_ready stays high.
- Redirect penalty: one bubble cycle, with if_valid low for exactly one cycle.
- Outputs change only on clk edges. rst_n assertion mid-operation clears all state immediately, discarding any held instruction.
- Redirect and stall together (redirect_valid=1, id_ready=0, if_valid=1): the redirect wins and the held instruction is dropped.

## Configuration
- FETCH_PERF_EN defined:
  - Adds output perf_fetched (32 bits): count of handshake transfers.
  - Adds output perf_stalls (32 bits): count of cycles with if_valid && !id_ready.
  - Both counters wrap modulo 2^32 and reset to 0.
- FETCH_PERF_EN undefined: these ports and counters do not exist.

## Structure
- Shared package mips_pkg holds:
  - INSTR_W = 32 and NOP_INSTR = 32'h0000_0000.
  - fetch state enum {RUN, FAULT}.
- One sub-module, pc_next, contains:
  - Next-PC mux (redirect / +4 / hold).
  - Alignment check and range check.
- The top module holds the PC register, IF/ID register, FSM and optional counters.

## Test plan
- Reset release, imem preloaded with 0x20080005 at word 0 and 0x20090007 at word 1, id_ready=1 → imem_addr 0 then 1; the first cycle shows if_instr 0x20080005, if_pc 0, if_pc_plus4 4, and the next cycle shows 0x20090007, if_pc 4.
- id_ready=0 for 3 cycles while if_valid=1 → if_instr, if_pc and imem_addr are stable for 3 cycles; perf_stalls = 3 with FETCH_PERF_EN.
- redirect_valid=1, redirect_pc=0x40 → next cycle if_valid=0 and imem_addr=0x10; the following cycle if_pc=0x40.
- redirect_pc=0x42 → fetch_fault=1 next cycle, if_valid stays 0; later redirects are ignored until rst_n pulses low.
- IMEM_WORDS=16, sequential run from 0 → 16 instructions delivered (if_pc 0..0x3C), then fetch_fault=1 and no 17th valid.
- rst_n pulsed low while if_valid=1 and stalled → if_valid=0 and pc=RESET_PC immediately, without waiting for clk.
